// File: rtl/xm23_mem_responder.sv
// XM23 memory responder: single-outstanding word/byte access to a little-endian
// pair of byte banks, with programmable wait states and a one-cycle done strobe.
module xm23_mem_responder #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ctrl,
  output logic [15:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy
);

  localparam int unsigned IDX_W = ADDR_W - 1;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [7:0]         rd_lb_q, rd_lb_d;
  logic [7:0]         rd_ub_q, rd_ub_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [7:0]         lb_mem [DEPTH];
  logic [7:0]         ub_mem [DEPTH];

  logic [IDX_W-1:0]   idx_c;
  logic               accept_c;
  logic               acc_err_c;
  logic               wr_lb_c;
  logic               wr_ub_c;
  logic [7:0]         wr_ub_data_c;

  // Decode of the latched request; upper address bits beyond ADDR_W alias.
  always_comb begin
    idx_c        = addr_q[ADDR_W-1:1];
    accept_c     = (state_q == S_IDLE) && req && (ctrl[1:0] != 2'b00);
    acc_err_c    = (ctrl_q[0] && ctrl_q[1]) || (!ctrl_q[2] && addr_q[0]);
    wr_lb_c      = (state_q == S_ACCESS) && ctrl_q[1] && !acc_err_c
                   && (!ctrl_q[2] || !addr_q[0]);
    wr_ub_c      = (state_q == S_ACCESS) && ctrl_q[1] && !acc_err_c
                   && (!ctrl_q[2] || addr_q[0]);
    wr_ub_data_c = ctrl_q[2] ? wdata_q[7:0] : wdata_q[15:8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    rd_lb_d = rd_lb_q;
    rd_ub_d = rd_ub_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        // The done cycle is spent in IDLE so a new request can be taken right after it.
        busy_d = accept_c;
        if (accept_c) begin
          addr_d  = addr;
          wdata_d = wdata;
          ctrl_d  = ctrl;
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        rd_lb_d = lb_mem[idx_c];
        rd_ub_d = ub_mem[idx_c];
        state_d = S_RESP;
      end
      S_RESP: begin
        done_d  = 1'b1;
        err_d   = acc_err_c;
        state_d = S_IDLE;
        if (acc_err_c) begin
          rdata_d = 16'h0000;
        end else if (ctrl_q[0]) begin
          if (ctrl_q[2]) begin
            rdata_d = {8'h00, (addr_q[0] ? rd_ub_q : rd_lb_q)};
          end else begin
            rdata_d = {rd_ub_q, rd_lb_q};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      rd_lb_q <= '0;
      rd_ub_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      rd_lb_q <= rd_lb_d;
      rd_ub_q <= rd_ub_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Byte banks are not reset so memory survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_lb_c) lb_mem[idx_c] <= wdata_q[7:0];
    if (wr_ub_c) ub_mem[idx_c] <= wr_ub_data_c;
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_xm23_mem_responder.sv
// Scoreboard bench for xm23_mem_responder: two instances (2 and 0 wait states)
// share stimulus and are checked against a byte-addressed reference memory.
module tb_xm23_mem_responder;

  localparam int unsigned WS_A = 2;
  localparam int unsigned WS_B = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b;
  logic [15:0] addr, wdata;
  logic [2:0]  ctrl;
  logic [15:0] rdata_a, rdata_b;
  logic        done_a, done_b, err_a, err_b, busy_a, busy_b;

  always #5 clk = ~clk;

  xm23_mem_responder #(.ADDR_W(16), .WAIT_STATES(WS_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .addr(addr), .wdata(wdata), .ctrl(ctrl),
    .rdata(rdata_a), .done(done_a), .err(err_a), .busy(busy_a)
  );

  xm23_mem_responder #(.ADDR_W(16), .WAIT_STATES(WS_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .addr(addr), .wdata(wdata), .ctrl(ctrl),
    .rdata(rdata_b), .done(done_b), .err(err_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic [31:0] acc;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic [7:0]  mem_m [int];
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] pool [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: little-endian byte memory, rdata held across writes, zeroed on error.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] wd,
                                 input logic [2:0] c, input int acc);
    exp_t e;
    int   ia;
    ia    = int'(a);
    e.acc = 32'(acc);
    e.err = (c[0] && c[1]) || (!c[2] && a[0]);
    if (e.err) begin
      e.rdata = 16'h0000;
    end else if (c[1]) begin
      mem_m[ia] = wd[7:0];
      if (!c[2]) mem_m[ia + 1] = wd[15:8];
      e.rdata = last_rd;
    end else if (c[2]) begin
      e.rdata = {8'h00, mem_m[ia]};
    end else begin
      e.rdata = {mem_m[ia + 1], mem_m[ia]};
    end
    last_rd = e.rdata;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] wd, input logic [2:0] c);
    exp_t e;
    addr  = a;
    wdata = wd;
    ctrl  = c;
    req_a = 1'b1;
    req_b = 1'b1;
    if (c[1:0] != 2'b00) begin
      e = model(a, wd, c, cyc + 1);
      qa.push_back(e);
      qb.push_back(e);
    end
    step();
    req_a = 1'b0;
    req_b = 1'b0;
    addr  = 16'($urandom);
    wdata = 16'($urandom);
    ctrl  = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
      step();
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++;
      $display("FAIL done_timeout: pending a=%0d b=%0d after %0d cycles", qa.size(), qb.size(), n);
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] wd, input logic [2:0] c);
    issue(a, wd, c);
    if (c[1:0] == 2'b00) repeat (WS_A + 4) step();
    wait_idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata_a"}, 32'(rdata_a), 32'h0);
    chk({tag, "_ctl_a"}, 32'({done_a, err_a, busy_a}), 32'h0);
    chk({tag, "_rdata_b"}, 32'(rdata_b), 32'h0);
    chk({tag, "_ctl_b"}, 32'({done_b, err_b, busy_b}), 32'h0);
  endtask

  // Monitor for the wait-state instance.
  logic prev_done_a = 1'b0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n) begin
      if (done_a) begin
        if (qa.size() == 0) begin
          checks++;
          $display("FAIL a_unexpected_done: rdata=%0h err=%0b expected no done", rdata_a, err_a);
        end else begin
          e = qa.pop_front();
          chk("a_rdata", 32'(rdata_a), 32'(e.rdata));
          chk("a_err", 32'(err_a), 32'(e.err));
          chk("a_latency", 32'(cyc), e.acc + 32'(WS_A) + 32'd2);
          chk("a_busy_at_done", 32'(busy_a), 32'h1);
        end
      end else if (qa.size() != 0 && 32'(cyc) >= qa[0].acc) begin
        chk("a_busy", 32'(busy_a), 32'h1);
      end else if (prev_done_a) begin
        chk("a_busy_after_done", 32'(busy_a), 32'h0);
      end
    end
    prev_done_a = done_a;
  end

  // Monitor for the zero-wait instance.
  logic prev_done_b = 1'b0;
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n) begin
      if (done_b) begin
        if (qb.size() == 0) begin
          checks++;
          $display("FAIL b_unexpected_done: rdata=%0h err=%0b expected no done", rdata_b, err_b);
        end else begin
          e = qb.pop_front();
          chk("b_rdata", 32'(rdata_b), 32'(e.rdata));
          chk("b_err", 32'(err_b), 32'(e.err));
          chk("b_latency", 32'(cyc), e.acc + 32'(WS_B) + 32'd2);
          chk("b_busy_at_done", 32'(busy_b), 32'h1);
        end
      end else if (qb.size() != 0 && 32'(cyc) >= qb[0].acc) begin
        chk("b_busy", 32'(busy_b), 32'h1);
      end else if (prev_done_b) begin
        chk("b_busy_after_done", 32'(busy_b), 32'h0);
      end
    end
    prev_done_b = done_b;
  end

  initial begin
    logic [15:0] a;
    req_a = 1'b0;
    req_b = 1'b0;
    addr  = '0;
    wdata = '0;
    ctrl  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) pool.push_back(16'h1000 + 16'(2 * i));
    pool.push_back(16'h2000);
    pool.push_back(16'hFFFE);
    foreach (pool[i]) op(pool[i], 16'($urandom), 3'b010);

    op(16'h1000, 16'hBEEF, 3'b010);
    op(16'h1000, 16'h0000, 3'b001);
    op(16'h1001, 16'h00AA, 3'b110);
    op(16'h1000, 16'h0000, 3'b001);
    op(16'h1001, 16'h0000, 3'b101);
    op(16'h1000, 16'h0000, 3'b101);
    op(16'h1003, 16'h0000, 3'b001);
    op(16'h1003, 16'h1234, 3'b010);
    op(16'h1002, 16'h0000, 3'b001);
    op(16'h1002, 16'h7777, 3'b011);
    op(16'h1002, 16'h0000, 3'b001);
    op(16'hFFFE, 16'hC0DE, 3'b010);
    op(16'hFFFE, 16'h0000, 3'b001);
    op(16'hFFFF, 16'h0000, 3'b101);
    op(16'h1004, 16'hFFFF, 3'b000);

    // Request pulsed while busy must be dropped.
    issue(16'h1010, 16'h1111, 3'b010);
    addr  = 16'h1010;
    wdata = 16'h2222;
    ctrl  = 3'b010;
    req_a = 1'b1;
    req_b = 1'b1;
    step();
    req_a = 1'b0;
    req_b = 1'b0;
    wait_idle();
    op(16'h1010, 16'h0000, 3'b001);

    // Reset during the wait phase aborts the write and suppresses done.
    addr  = 16'h2000;
    wdata = 16'h5555;
    ctrl  = 3'b010;
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    step();
    rst_n = 1'b0;
    #2 chk_zero("abort");
    step();
    step();
    rst_n   = 1'b1;
    last_rd = 16'h0000;
    repeat (WS_A + 4) step();
    chk_zero("post_abort");
    op(16'h2000, 16'h0000, 3'b001);

    for (int i = 0; i < 200; i++) begin
      a = pool[$urandom_range(pool.size() - 1)] + 16'($urandom_range(1));
      op(a, 16'($urandom), 3'($urandom));
    end

    repeat (4) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
